// File: rtl/servo_joint_drive_pkg.sv
// Shared constants and types for the servo joint drive and its tick divider.
package servo_pkg;

  localparam int unsigned POS_W = 8;

  localparam logic [1:0] BTN_HOLD = 2'b00;
  localparam logic [1:0] BTN_DEC  = 2'b01;
  localparam logic [1:0] BTN_INC  = 2'b10;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/servo_joint_drive_if.sv
// Command / status bundle between the move decoder and one joint drive.
interface servo_joint_drive_if;

  logic                        en;
  logic [1:0]                  btn;
  logic [servo_pkg::POS_W-1:0] pos;
  logic                        pwm;
  logic                        at_limit;
  logic                        frame_stb;

  modport master (
    output en, btn,
    input  pos, pwm, at_limit, frame_stb
  );

  modport slave (
    input  en, btn,
    output pos, pwm, at_limit, frame_stb
  );

endinterface

// File: rtl/servo_joint_drive_tick_div.sv
// Free-running divider: one-cycle tick every DIV clocks.
module tick_div #(
  parameter int unsigned DIV = 500_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/servo_joint_drive.sv
// Joint drive: rate-limited saturating position integrator plus 50 Hz servo PWM.
module servo_joint_drive
  import servo_pkg::*;
#(
  parameter int unsigned PWM_PERIOD_CYC = 2_000_000,
  parameter int unsigned PULSE_MIN_CYC  = 100_000,
  parameter int unsigned STEP_CYC       = 392,
  parameter int unsigned RATE_DIV       = 500_000,
  parameter logic [POS_W-1:0] POS_RESET = 8'd128
) (
  input  logic                clk,
  input  logic                rst,
  servo_joint_drive_if.slave  bus
);

  localparam int unsigned FC_W =
    ($clog2(PWM_PERIOD_CYC) > 22) ? $clog2(PWM_PERIOD_CYC) : 22;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(PWM_PERIOD_CYC - 1);

  logic             tick;
  logic [POS_W-1:0] pos_q, pos_d;
  state_t           state_q, state_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic [FC_W-1:0]  width_q, width_d;
  logic             pwm_q, pwm_d;
  logic             stb_q, stb_d;

  tick_div #(.DIV(RATE_DIV)) u_rate (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    pos_d = pos_q;
    if (tick && bus.en) begin
      unique case (bus.btn)
        BTN_INC: if (pos_q != '1) pos_d = pos_q + POS_W'(1);
        BTN_DEC: if (pos_q != '0) pos_d = pos_q - POS_W'(1);
        default: pos_d = pos_q;
      endcase
    end
  end

  // pwm/frame_stb are registered, so the pulse lags fc by one cycle; the
  // high time still equals width cycles and reset clears pwm immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q   <= POS_RESET;
      state_q <= LOAD;
      fc_q    <= '0;
      width_q <= '0;
      pwm_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      state_q <= state_d;
      fc_q    <= fc_d;
      width_q <= width_d;
      pwm_q   <= pwm_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q + FC_W'(1);
    if (fc_q == FC_LAST) begin
      fc_d    = '0;
      state_d = LOAD;
    end else begin
      unique case (state_q)
        LOAD:    state_d = HIGH;
        HIGH:    if (fc_q >= width_q) state_d = LOW;
        LOW:     state_d = LOW;
        default: state_d = LOAD;
      endcase
    end
  end

  always_comb begin
    width_d = width_q;
    pwm_d   = 1'b0;
    stb_d   = 1'b0;
    unique case (state_q)
      LOAD: begin
        width_d = FC_W'(PULSE_MIN_CYC) + FC_W'(pos_q) * FC_W'(STEP_CYC);
        pwm_d   = 1'b1;
        stb_d   = 1'b1;
      end
      HIGH:    pwm_d = (fc_q < width_q);
      default: pwm_d = 1'b0;
    endcase
  end

  assign bus.pos       = pos_q;
  assign bus.pwm       = pwm_q;
  assign bus.frame_stb = stb_q;
  assign bus.at_limit  = ((pos_q == '0) && (bus.btn == BTN_DEC)) ||
                         ((pos_q == '1) && (bus.btn == BTN_INC));

endmodule

// File: tb/tb_servo_joint_drive.sv
// Directed bench for servo_joint_drive with shortened frame and step timing.
module tb_servo_joint_drive;
  import servo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  servo_joint_drive_if bus();

  servo_joint_drive #(
    .PWM_PERIOD_CYC (400),
    .PULSE_MIN_CYC  (20),
    .STEP_CYC       (1),
    .RATE_DIV       (4),
    .POS_RESET      (8'd128)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned hi_acc    = 0;
  int unsigned len_acc   = 0;
  int unsigned last_high = 0;
  int unsigned last_len  = 0;
  int unsigned stb_cnt   = 0;

  // Measures pwm high time and frame length between consecutive frame strobes.
  always @(negedge clk) begin
    if (rst) begin
      hi_acc  = 0;
      len_acc = 0;
    end else if (bus.frame_stb) begin
      last_high = hi_acc;
      last_len  = len_acc;
      hi_acc    = (bus.pwm === 1'b1) ? 1 : 0;
      len_acc   = 1;
      stb_cnt++;
    end else begin
      if (bus.pwm === 1'b1) hi_acc++;
      len_acc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frame();
    int unsigned start;
    bit seen;
    start = stb_cnt;
    seen  = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (stb_cnt != start) seen = 1'b1;
    end
    if (!seen) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic ramp(input logic [1:0] b, input int unsigned n, input string tag,
                      input logic [7:0] bad);
    bit hit;
    hit = 1'b0;
    bus.btn = b;
    for (int i = 0; i < int'(n); i++) begin
      cyc(1);
      if (bus.pos === bad) hit = 1'b1;
    end
    check(tag, {31'd0, hit}, 32'd0);
  endtask

  initial begin
    bus.en  = 1'b1;
    bus.btn = BTN_HOLD;
    rst     = 1'b1;

    // 1: reset state and nominal frame
    cyc(3);
    check("rst_pos", bus.pos, 128);
    check("rst_pwm", bus.pwm, 0);
    check("rst_stb", bus.frame_stb, 0);
    check("rst_lim", bus.at_limit, 0);
    rst = 1'b0;
    cyc(1);
    check("first_stb", bus.frame_stb, 1);
    check("first_pwm", bus.pwm, 1);
    cyc(1);
    check("stb_one_cycle", bus.frame_stb, 0);
    wait_frame();
    check("high_128", last_high, 148);
    check("len_128", last_len, 400);

    // 2: ten steps up
    cyc(1);
    bus.btn = BTN_INC;
    cyc(40);
    bus.btn = BTN_HOLD;
    check("pos_138", bus.pos, 138);
    wait_frame();
    wait_frame();
    check("high_138", last_high, 158);
    check("len_138", last_len, 400);

    // 3: saturation at 255
    cyc(1);
    bus.btn = BTN_INC;
    cyc(464);
    bus.btn = BTN_HOLD;
    check("pos_254", bus.pos, 254);
    check("lim_254", bus.at_limit, 0);
    ramp(BTN_INC, 20, "inc_wrap", 8'd0);
    check("pos_255", bus.pos, 255);
    check("lim_255", bus.at_limit, 1);

    // 4: hold cases at 255
    bus.en = 1'b0;
    cyc(100);
    check("en0_pos_255", bus.pos, 255);
    check("en0_lim_255", bus.at_limit, 1);
    bus.en  = 1'b1;
    bus.btn = 2'b11;
    cyc(100);
    check("btn11_pos_255", bus.pos, 255);
    check("btn11_lim_255", bus.at_limit, 0);

    // 3b: saturation at 0
    bus.btn = BTN_DEC;
    cyc(1016);
    check("pos_1", bus.pos, 1);
    check("lim_1", bus.at_limit, 0);
    ramp(BTN_DEC, 20, "dec_wrap", 8'd255);
    check("pos_0", bus.pos, 0);
    check("lim_0", bus.at_limit, 1);

    // 4b: hold cases at 0
    bus.btn = 2'b11;
    cyc(100);
    check("btn11_pos_0", bus.pos, 0);
    check("btn11_lim_0", bus.at_limit, 0);
    bus.en  = 1'b0;
    bus.btn = BTN_INC;
    cyc(100);
    check("en0_inc_pos_0", bus.pos, 0);
    check("en0_inc_lim_0", bus.at_limit, 0);
    bus.btn = BTN_DEC;
    cyc(4);
    check("en0_dec_pos_0", bus.pos, 0);
    check("en0_dec_lim_0", bus.at_limit, 1);

    // 5: mid-frame position change
    bus.en  = 1'b1;
    bus.btn = BTN_INC;
    cyc(400);
    bus.btn = BTN_HOLD;
    check("pos_100", bus.pos, 100);
    wait_frame();
    wait_frame();
    check("high_100", last_high, 120);
    repeat (49) @(posedge clk);
    #1;
    bus.btn = BTN_INC;
    cyc(40);
    bus.btn = BTN_HOLD;
    check("pos_110", bus.pos, 110);
    check("mid_pwm", bus.pwm, 1);
    wait_frame();
    check("high_unchanged", last_high, 120);
    wait_frame();
    check("high_110", last_high, 130);

    // 6: reset during the high phase
    cyc(29);
    check("pre_rst_pwm", bus.pwm, 1);
    rst = 1'b1;
    cyc(1);
    check("midrst_pwm", bus.pwm, 0);
    check("midrst_pos", bus.pos, 128);
    check("midrst_stb", bus.frame_stb, 0);
    rst = 1'b0;
    cyc(1);
    check("rel_stb", bus.frame_stb, 1);
    check("rel_pwm", bus.pwm, 1);
    cyc(1);
    wait_frame();
    check("rel_high", last_high, 148);
    check("rel_len", last_len, 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
